// File: rtl/instr_mem_pipe.sv
// instr_mem_pipe: pipelined RV32I instruction memory with a credit-controlled response FIFO.
// Define INSTR_MEM_WRITE_EN to add a byte-masked boot-load write port; otherwise the array is a ROM.
module instr_mem_pipe #(
  parameter string MEM_FILE   = "",
  parameter int    DEPTH      = 1024,
  parameter int    LATENCY    = 1,
  parameter int    RESP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  input  logic        flush
`ifdef INSTR_MEM_WRITE_EN
  ,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_mask
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = $clog2(RESP_DEPTH);

  logic [31:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Request decode and credit check
  logic [AW-1:0] req_idx;
  logic          req_err;
  logic          accept;
  logic [CW-1:0] inflight_reg;
  logic [CW-1:0] count_reg;
  logic [CW:0]   credit_used;

  assign req_idx     = req_addr[AW+1:2];
  assign req_err     = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
  assign credit_used = {1'b0, inflight_reg} + {1'b0, count_reg};
  assign req_ready   = !rst && !flush && (credit_used < (CW+1)'(RESP_DEPTH));
  assign accept      = req_valid && req_ready;

  // Read pipeline: stage 0 is the RAM read register, the rest are plain delay stages
  logic        pipe_valid_reg [LATENCY];
  logic [31:0] pipe_data_reg  [LATENCY];
  logic        pipe_err_reg   [LATENCY];

  always_ff @(posedge clk) begin
    if (accept) begin
      pipe_data_reg[0] <= mem[req_idx];
      pipe_err_reg[0]  <= req_err;
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_data_reg[i] <= pipe_data_reg[i-1];
      pipe_err_reg[i]  <= pipe_err_reg[i-1];
    end
    if (rst || flush) begin
      for (int i = 0; i < LATENCY; i++) pipe_valid_reg[i] <= 1'b0;
    end else begin
      pipe_valid_reg[0] <= accept;
      for (int i = 1; i < LATENCY; i++) pipe_valid_reg[i] <= pipe_valid_reg[i-1];
    end
  end

  logic        out_valid;
  logic        out_err;
  logic [31:0] out_data;

  assign out_valid = pipe_valid_reg[LATENCY-1];
  assign out_err   = pipe_err_reg[LATENCY-1];
  assign out_data  = out_err ? 32'h0 : pipe_data_reg[LATENCY-1];

  // Response FIFO; when it is empty the pipeline output is presented directly,
  // and an unconsumed bypassed response lands at the head on the next edge.
  logic [31:0]   fifo_data_reg [RESP_DEPTH];
  logic          fifo_err_reg  [RESP_DEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic          fifo_empty;
  logic          bypass_take;
  logic          push;
  logic          pop;

  assign fifo_empty  = (count_reg == '0);
  assign bypass_take = fifo_empty && out_valid && resp_ready;
  assign push        = out_valid && !bypass_take;
  assign pop         = !fifo_empty && resp_ready;

  assign resp_valid = fifo_empty ? out_valid : 1'b1;
  assign resp_data  = fifo_empty ? (out_valid ? out_data : 32'h0) : fifo_data_reg[rd_ptr_reg];
  assign resp_err   = fifo_empty ? (out_valid && out_err) : fifo_err_reg[rd_ptr_reg];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_reg[wr_ptr_reg] <= out_data;
      fifo_err_reg[wr_ptr_reg]  <= out_err;
    end
    if (rst || flush) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg    <= count_reg + CW'(push) - CW'(pop);
      // every valid pipeline output leaves the pipe at the edge (pushed or bypassed)
      inflight_reg <= inflight_reg + CW'(accept) - CW'(out_valid);
    end
  end

`ifdef INSTR_MEM_WRITE_EN
  logic [AW-1:0] wr_idx;
  logic          wr_in_range;
  logic          unused_wr_low;

  assign wr_idx        = wr_addr[AW+1:2];
  assign wr_in_range   = (wr_addr[31:AW+2] == '0);
  assign unused_wr_low = ^wr_addr[1:0];

  // Separate write block; reads above see pre-write contents (read-first)
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end
`endif

endmodule
